stream_fifo: RTL and testbench
==============================

# stream_fifo

Parametrised synchronous valid/ready stream FIFO that decouples a producer port from a consumer port on one clock domain. It sits between interface-connected blocks on the signal paths: the producer drives the slave side and the consumer reads the master side. It generalises the fixed single-register stage with configurable data width, depth and almost-full threshold, plus occupancy reporting, synchronous flush and an optional high-water-mark monitor.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1).
- DEPTH, 8, number of entries; power of two, ≥2.
- AFULL_THRESH, DEPTH-2, `almost_full` asserts when count ≥ this value; legal range 1..DEPTH.
- Derived: CW = $clog2(DEPTH)+1, the count width.

- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all contents.
- s_valid  input  1  producer has data.
- s_ready  output  1  FIFO can accept; high when count < DEPTH.
- s_data  input  DATA_WIDTH  producer payload.
- m_valid  output  1  FIFO holds data; high when count > 0.
- m_ready  input  1  consumer accepts.
- m_data  output  DATA_WIDTH  head entry; valid only while m_valid is high.
- count  output  CW  current occupancy, 0..DEPTH.
- almost_full  output  1  count ≥ AFULL_THRESH.

## Operation
- Push when s_valid && s_ready. Pop when m_valid && m_ready.
- Storage: DEPTH-entry array with write and read pointers of width $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0 naturally.
- count is held in a register: +1 on push only, -1 on pop only, and unchanged on push and pop in the same cycle.
- s_ready depends only on registered state, never on m_ready. When full, a same-cycle pop does not enable a push.
- m_valid and s_ready depend only on registered state. There is no combinational path from input to output handshake.
- Push with pop on an empty FIFO is impossible, because m_valid is low. The pushed word appears the next cycle.
- flush has priority over push and pop in the same cycle. Pointers and count go to 0, and incoming data is discarded.
- s_data and m_data are not checked for X. The array itself is not reset.
- A write to mem[wr_ptr] never aliases the read of head data except when empty, and in that case m_valid is low.

## Timing
- Reset values: s_ready=1, m_valid=0, count=0, almost_full=0, m_data=don't-care. Pointers are 0.
- Write-to-read latency: 1 cycle. A word pushed at edge N is presented on m_data with m_valid=1 after edge N.
- m_data is read combinationally from array[rd_ptr]. It is stable while m_valid && !m_ready.
- Sustained throughput: 1 word/cycle when not full and not empty.
- count and almost_full update on the same edge as the push or pop that changes them.
- Reset asserted mid-transfer immediately forces the reset values above. In-flight data is lost, and the first push after deassertion writes entry 0.

## Configuration
- STREAM_FIFO_HWM_EN: when defined, adds output `hwm` (CW bits), the maximum count reached since reset.
  - hwm updates on the same edge as count.
  - hwm is cleared only by rst, not by flush.
  - Without the macro, the port and its register are absent, and behaviour is otherwise identical.

## Test plan
- Reset then idle: after rst release, s_ready=1, m_valid=0, count=0, almost_full=0 (and hwm=0 if enabled).
- Fill with DEPTH=8, AFULL_THRESH=6, and m_ready=0. Push 0x00..0x07:
  - almost_full rises after the 6th push.
  - s_ready falls after the 8th push; count=8.
  - A 9th s_valid is not accepted.
- Drain: from full, hold m_ready=1. Output is 0x00..0x07 in order, one per cycle. m_valid falls after the 8th pop; count=0.
- Wrap and streaming: continuously push 20 incrementing words with m_ready=1. Output order is preserved across pointer wrap, count stays at 1 after the first cycle, and there are no bubbles.
- Simultaneous events:
  - At count=3, push and pop in the same cycle: count stays 3.
  - Flush asserted with s_valid=1 and m_ready=1: next cycle count=0, m_valid=0, and the pushed word never appears.
- Reset mid-operation: with count=5, assert rst asynchronously between edges. Outputs return to reset values before the next edge. Then push 0xAB, and it emerges as the first word. With STREAM_FIFO_HWM_EN, hwm=5 before the reset and 1 after.

Source files
------------

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//
// Synchronous valid/ready stream FIFO that decouples a producer from a
// consumer on a single clock domain. Storage is a DEPTH-entry array addressed
// by wrapping write/read pointers. Occupancy is held in a dedicated counter,
// so the handshake outputs are decoded from registered state only.
//
// Optional feature (macro STREAM_FIFO_HWM_EN): adds output `hwm`, the highest
// occupancy reached since reset. It is cleared by rst only, never by flush.
//
// Parameters:
//   DATA_WIDTH   payload width in bits (>= 1)
//   DEPTH        number of entries, power of two, >= 2
//   AFULL_THRESH almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous clear; wins over push and pop
//   s_valid      producer has data
//   s_ready      FIFO can accept (count < DEPTH)
//   s_data       producer payload
//   m_valid      FIFO holds data (count > 0)
//   m_ready      consumer accepts
//   m_data       head entry, meaningful only while m_valid is high
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AFULL_THRESH
//   hwm          (STREAM_FIFO_HWM_EN only) max count since reset
// -----------------------------------------------------------------------------
module stream_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 8,
   parameter int AFULL_THRESH = DEPTH - 2,
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CW-1:0]         count,
   output logic                  almost_full
`ifdef STREAM_FIFO_HWM_EN
   ,
   output logic [CW-1:0]         hwm
`endif
);

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_next;
   logic                  push;
   logic                  pop;

   // Handshakes decode registered occupancy only: a pop in the same cycle
   // never opens s_ready when full, so there is no ready-to-ready path.
   assign s_ready     = (count < FULL_CNT);
   assign m_valid     = (count != '0);
   assign almost_full = (count >= AFULL_CNT);
   assign push        = s_valid && s_ready;
   assign pop         = m_valid && m_ready;

   // Head is read combinationally. The write slot only equals rd_ptr when the
   // FIFO is empty, and then m_valid is low, so no bypass is needed.
   assign m_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; every entry is written before it
   // can be observed with m_valid high, and leaving it unreset lets it map
   // onto plain RAM/flops without a reset network.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= s_data;
      end
   end

   // NOTE: all state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_next;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by overflow.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

`ifdef STREAM_FIFO_HWM_EN
   // Tracks count_next so the mark moves on the same edge as count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hwm <= '0;
      end else if (count_next > hwm) begin
         hwm <= count_next;
      end
   end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//
// Directed bench for stream_fifo with DEPTH=8, AFULL_THRESH=6, DATA_WIDTH=8.
// Inputs change 1 ns after each rising edge and outputs are sampled there too,
// so every observation is away from the active edge. Expected values are
// written out by hand in each step.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

   localparam int DW = 8;
   localparam int DP = 8;
   localparam int AF = 6;
   localparam int CW = $clog2(DP) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [CW-1:0] count;
   logic          almost_full;
`ifdef STREAM_FIFO_HWM_EN
   logic [CW-1:0] hwm;
`endif

   int passed = 0;
   int total  = 0;

   stream_fifo #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DP),
      .AFULL_THRESH (AF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
      .almost_full (almost_full)
`ifdef STREAM_FIFO_HWM_EN
      ,
      .hwm         (hwm)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // One rising edge with the current inputs, then settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      #12;
      rst = 1'b0;
      #1;

      // ---------------- reset then idle ----------------
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_afull", 32'(almost_full), 32'd0);
`ifdef STREAM_FIFO_HWM_EN
      check("rst_hwm", 32'(hwm), 32'd0);
`endif
      step();

      // ---------------- fill 0x00..0x07 ----------------
      s_valid = 1'b1;
      for (int i = 0; i < DP; i++) begin
         s_data = DW'(i);
         step();
         check("fill_count", 32'(count), 32'(i + 1));
         check("fill_afull", 32'(almost_full), (i + 1 >= AF) ? 32'd1 : 32'd0);
         check("fill_s_ready", 32'(s_ready), (i + 1 < DP) ? 32'd1 : 32'd0);
         check("fill_head", 32'(m_data), 32'h00);
      end
      // A 9th offer while full must be refused.
      s_data = 8'h99;
      step();
      check("full_count", 32'(count), 32'd8);
      check("full_s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b0;

      // ---------------- drain in order ----------------
      m_ready = 1'b1;
      for (int i = 0; i < DP; i++) begin
         check("drain_m_valid", 32'(m_valid), 32'd1);
         check("drain_data", 32'(m_data), 32'(i));
         step();
         check("drain_count", 32'(count), 32'(DP - 1 - i));
      end
      check("drain_m_valid_low", 32'(m_valid), 32'd0);
      check("drain_afull_low", 32'(almost_full), 32'd0);

      // ---------------- streaming across wrap ----------------
      // Each cycle the just-pushed word is the head: no bubbles, order kept.
      s_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_data = 8'h40 + DW'(i);
         step();
         check("stream_count", 32'(count), 32'd1);
         check("stream_data", 32'(m_data), 32'h40 + 32'(i));
      end
      s_valid = 1'b0;
      step();
      check("stream_end_count", 32'(count), 32'd0);
      check("stream_end_m_valid", 32'(m_valid), 32'd0);
      m_ready = 1'b0;

      // ---------------- simultaneous push and pop at count=3 ----------------
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'h10 + DW'(i);
         step();
      end
      check("sim_pre_count", 32'(count), 32'd3);
      s_data  = 8'h13;
      m_ready = 1'b1;
      check("sim_head", 32'(m_data), 32'h10);
      step();
      check("sim_count", 32'(count), 32'd3);
      check("sim_next_head", 32'(m_data), 32'h11);
      s_valid = 1'b0;
      m_ready = 1'b0;

      // ---------------- flush beats push and pop ----------------
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hEE;
      m_ready = 1'b1;
      step();
      flush   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_m_valid", 32'(m_valid), 32'd0);
      check("flush_s_ready", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = 8'h77;
      step();
      s_valid = 1'b0;
      check("post_flush_data", 32'(m_data), 32'h77);
      check("post_flush_count", 32'(count), 32'd1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("post_flush_empty", 32'(count), 32'd0);

      // ---------------- async reset mid-operation ----------------
      // Fresh reset first so the high-water mark starts from zero.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_data = 8'h20 + DW'(i);
         step();
      end
      s_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd5);
`ifdef STREAM_FIFO_HWM_EN
      check("pre_rst_hwm", 32'(hwm), 32'd5);
`endif
      #2;
      rst = 1'b1;
      #1;
      // Still before the next rising edge.
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_m_valid", 32'(m_valid), 32'd0);
      check("mid_rst_s_ready", 32'(s_ready), 32'd1);
      check("mid_rst_afull", 32'(almost_full), 32'd0);
`ifdef STREAM_FIFO_HWM_EN
      check("mid_rst_hwm", 32'(hwm), 32'd0);
`endif
      rst = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hAB;
      step();
      s_valid = 1'b0;
      check("after_rst_m_valid", 32'(m_valid), 32'd1);
      check("after_rst_data", 32'(m_data), 32'hAB);
      check("after_rst_count", 32'(count), 32'd1);
`ifdef STREAM_FIFO_HWM_EN
      check("after_rst_hwm", 32'(hwm), 32'd1);
`endif
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("final_count", 32'(count), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
